lsu_mem_master: RTL and testbench

Load/store initiator that drives the read/write port of the core's dual-port RAM on behalf of the execute stage. It accepts one byte, half or word request over a valid/ready handshake and checks alignment. It issues RAM accesses using only the write masks the RAM supports: 1111, 0011 and 0001. Sub-word stores at nonzero byte offsets use read-modify-write. Load data is extracted and sign- or zero-extended before being returned over a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_mem_master_align.sv | 35 +++
 rtl/lsu_mem_master.sv | 111 +++++++++++
 tb/tb_lsu_mem_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory master
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef logic [2:0] state_e;

    localparam state_e S_IDLE      = 3'd0;
    localparam state_e S_READ      = 3'd1;
    localparam state_e S_READ_WAIT = 3'd2;
    localparam state_e S_WRITE     = 3'd3;
    localparam state_e S_RESP      = 3'd4;

    localparam logic [3:0] WE_WORD = 4'b1111;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_NONE = 4'b0000;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rmw;
    } req_t;

endpackage

// File: rtl/lsu_mem_master_align.sv
// lsu_align: alignment check, write-mask choice, store merge and load extraction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic        err_o,
    output logic        rmw_o,
    output logic [3:0]  we_o,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] shifted;

    assign sh = {off_i, 3'b000};

    // Decode legality and build both the RMW merge word and the extended load value
    always_comb begin
        err_o    = (size_i == 2'b11) || (size_i == HALF && off_i[0]) || (size_i == WORD && off_i != 2'b00);
        rmw_o    = !err_o && size_i != WORD && off_i != 2'b00;
        we_o     = size_i == WORD ? WE_WORD : size_i == HALF ? WE_HALF : WE_BYTE;
        lane     = (size_i == HALF ? 32'h0000_ffff : 32'h0000_00ff) << sh;
        merged_o = (rword_i & ~lane) | ((wdata_i << sh) & lane);
        shifted  = rword_i >> sh;
        load_o   = size_i == BYTE ? {{24{signed_i & shifted[7]}}, shifted[7:0]} :
                   size_i == HALF ? {{16{signed_i & shifted[15]}}, shifted[15:0]} : shifted;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator for the RAM read/write port
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter bit SYNC_READ = 1'b0
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_din_o,
    input  logic [31:0] mem_dout_i
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        idle, mem_act;
    logic        a_err, a_rmw;
    logic [3:0]  a_we;
    logic [31:0] a_merged, a_load;

    assign idle    = state_q == S_IDLE;
    assign mem_act = state_q == S_READ || state_q == S_READ_WAIT || state_q == S_WRITE;

    // Legality is judged on the incoming request in IDLE, on the latched one afterwards
    lsu_align u_align (
        .size_i   (idle ? req_size_i : req_q.size),
        .off_i    (idle ? req_addr_i[1:0] : req_q.addr[1:0]),
        .signed_i (req_q.sgn),
        .wdata_i  (req_q.wdata),
        .rword_i  (mem_dout_i),
        .err_o    (a_err),
        .rmw_o    (a_rmw),
        .we_o     (a_we),
        .merged_o (a_merged),
        .load_o   (a_load)
    );

    // Next-state: accept, read (optional wait), write, then hold the response
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                req_d   = '{req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i, a_rmw};
                err_d   = a_err;
                rdata_d = 32'h0;
                state_d = a_err ? S_RESP : (!req_we_i || a_rmw) ? S_READ : S_WRITE;
            end
            S_READ, S_READ_WAIT: if (SYNC_READ && state_q == S_READ) begin
                state_d = S_READ_WAIT;
            end else begin
                word_d  = a_merged;
                rdata_d = req_q.we ? 32'h0 : a_load;
                state_d = req_q.we ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: if (rsp_ready_i) begin
                state_d = S_IDLE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request/response registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = idle;
    assign rsp_valid_o = state_q == S_RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_en_o    = mem_act;
    assign mem_addr_o  = mem_act ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign mem_we_o    = state_q == S_WRITE ? (req_q.rmw ? WE_WORD : a_we) : WE_NONE;
    assign mem_din_o   = state_q == S_WRITE ? (req_q.rmw ? word_q : req_q.wdata) : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed checks of async and sync-read variants against a RAM model
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        rdy0, rv0, er0, en0, rdy1, rv1, er1, en1;
    logic [31:0] rd0, ma0, din0, rd1, ma1, din1, dout0, dout1;
    logic [3:0]  we0, we1;

    logic [31:0] ram [0:63];

    int total = 0, bad = 0;
    int lat, wr_cnt;
    logic en_seen, rd_seen, er;
    logic [3:0]  wr_we;
    logic [31:0] wr_din, rd;

    always #5 clk = ~clk;

    lsu_mem_master #(.SYNC_READ(1'b0)) u_dut0 (
        .clk(clk), .rstn_i(rstn), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
        .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv0),
        .rsp_ready_i(rsp_ready & ~sel), .rsp_rdata_o(rd0), .rsp_err_o(er0),
        .mem_addr_o(ma0), .mem_en_o(en0), .mem_we_o(we0), .mem_din_o(din0), .mem_dout_i(dout0)
    );

    lsu_mem_master #(.SYNC_READ(1'b1)) u_dut1 (
        .clk(clk), .rstn_i(rstn), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv1),
        .rsp_ready_i(rsp_ready & sel), .rsp_rdata_o(rd1), .rsp_err_o(er1),
        .mem_addr_o(ma1), .mem_en_o(en1), .mem_we_o(we1), .mem_din_o(din1), .mem_dout_i(dout1)
    );

    logic        m_rv, m_err, m_en, m_rdy;
    logic [3:0]  m_we;
    logic [31:0] m_rdata, m_addr, m_din;
    assign m_rv    = sel ? rv1 : rv0;
    assign m_err   = sel ? er1 : er0;
    assign m_en    = sel ? en1 : en0;
    assign m_rdy   = sel ? rdy1 : rdy0;
    assign m_we    = sel ? we1 : we0;
    assign m_rdata = sel ? rd1 : rd0;
    assign m_addr  = sel ? ma1 : ma0;
    assign m_din   = sel ? din1 : din0;

    assign dout0 = ram[ma0[7:2]];

    always @(posedge clk) begin
        if (en1) dout1 <= ram[ma1[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (en0 && we0[b]) ram[ma0[7:2]][8*b +: 8] <= din0[8*b +: 8];
            if (en1 && we1[b]) ram[ma1[7:2]][8*b +: 8] <= din1[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input logic [31:0] exp_hold);
        sel = s;
        @(negedge clk);
        req_we = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wr_cnt = 0; en_seen = 1'b0; rd_seen = 1'b0; wr_we = 4'h0; wr_din = 32'h0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (m_en) en_seen = 1'b1;
            if (m_en && m_we == 4'h0) rd_seen = 1'b1;
            if (m_we != 4'h0) begin
                wr_cnt++;
                wr_we  = m_we;
                wr_din = m_din;
            end
            if (m_rv) break;
        end
        rd = m_rdata;
        er = m_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, m_rv}, 32'h1);
            check("hold_rdata", m_rdata, exp_hold);
            check("hold_ready", {31'h0, m_rdy}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_drop", {31'h0, m_rv}, 32'h0);
        check("ready_back", {31'h0, m_rdy}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[8]  = 32'h1122_3344;
        ram[16] = 32'h80F0_7F01;
        ram[20] = 32'h5566_7788;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'h0, rdy0}, 32'h1);
        check("rst_outs", {rv0, er0, en0, we0, 25'h0}, 32'h0);
        check("rst_addr_din_rdata", ma0 | din0 | rd0, 32'h0);

        run(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        check("sw_lat", lat, 2);
        check("sw_wr_cnt", wr_cnt, 1);
        check("sw_we", {28'h0, wr_we}, 32'hF);
        check("sw_din", wr_din, 32'hDEADBEEF);
        check("sw_err_rdata", {31'h0, er} | rd, 32'h0);
        check("sw_ram", ram[4], 32'hDEADBEEF);

        run(1'b0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 0, 32'h0);
        check("lw_lat", lat, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", {31'h0, er}, 32'h0);
        check("lw_no_write", wr_cnt, 0);

        run(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 0, 32'h0);
        check("sb_rmw_lat", lat, 3);
        check("sb_rmw_read", {31'h0, rd_seen}, 32'h1);
        check("sb_rmw_din", wr_din, 32'h11AA_3344);
        check("sb_rmw_we", {28'h0, wr_we}, 32'hF);
        check("sb_rmw_ram", ram[8], 32'h11AA_3344);

        run(1'b0, 1'b0, 2'b00, 1'b1, 32'h42, 32'h0, 0, 32'h0);
        check("lb_s_off2", rd, 32'hFFFF_FFF0);
        run(1'b0, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 0, 32'h0);
        check("lhu_off2", rd, 32'h0000_80F0);
        run(1'b0, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 0, 32'h0);
        check("lh_s_off0", rd, 32'h0000_7F01);
        run(1'b0, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 0, 32'h0);
        check("lbu_off3", rd, 32'h0000_0080);

        run(1'b0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h1234, 0, 32'h0);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_err", {31'h0, er}, 32'h1);
        check("sh_mis_rdata", rd, 32'h0);
        check("sh_mis_no_en", {31'h0, en_seen}, 32'h0);
        run(1'b0, 1'b0, 2'b10, 1'b0, 32'h32, 32'h0, 0, 32'h0);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_err", {31'h0, er}, 32'h1);
        check("lw_mis_no_en", {31'h0, en_seen}, 32'h0);
        run(1'b0, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0, 32'h0);
        check("size11_err", {31'h0, er}, 32'h1);
        check("size11_no_en", {31'h0, en_seen}, 32'h0);

        run(1'b0, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 5, 32'h0000_80F0);
        check("hold_lat", lat, 2);

        run(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF);
        check("sync_lw_lat", lat, 3);
        check("sync_lw_rdata", rd, 32'hDEADBEEF);
        run(1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 0, 32'h0);
        check("sync_lbu_off1", rd, 32'h0000_007F);
        run(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 0, 32'h0);
        check("sync_rmw_lat", lat, 4);
        check("sync_rmw_din", wr_din, 32'hBEEF_BEEF);
        check("sync_rmw_ram", ram[4], 32'hBEEF_BEEF);
        run(1'b1, 1'b1, 2'b00, 1'b0, 32'h14, 32'h0000_0055, 0, 32'h0);
        check("sync_sb_direct_lat", lat, 2);
        check("sync_sb_direct_we", {28'h0, wr_we}, 32'h1);

        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h51; req_wdata = 32'h99;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_in_read", {31'h0, en0}, 32'h1);
        rstn = 1'b0;
        #1;
        check("arst_outs", {rv0, er0, en0, we0, 25'h0}, 32'h0);
        check("arst_addr_din_rdata", ma0 | din0 | rd0, 32'h0);
        check("arst_ready", {31'h0, rdy0}, 32'h1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_ram_kept", ram[20], 32'h5566_7788);
        check("arst_ready_after", {31'h0, rdy0}, 32'h1);
        run(1'b0, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 0, 32'h0);
        check("post_rst_lat", lat, 2);
        check("post_rst_rdata", rd, 32'h5566_7788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
